pipe_reg_bus_reader: RTL
========================

// Module: pipe_reg_bus_reader
// PURPOSE
//  Reader side of the tristate pipeline-register bus. Scans a bank of pipeline registers whose Q
//  outputs share one bus and float when their cs input is 1. Selects one register at a time
//  (cs=0), waits for the bus to settle, then captures the value. Streams each captured word
//  out over a valid/ready link to the debug/display path. Sits beside the pipeline registers.
// PARAMETERS
//  NrOfBits      32  width of the shared register bus and of OutData
//  NrOfRegs       8  number of registers on the bus (>=1); IdxW = max(1,clog2(NrOfRegs))
//  SettleCycles   1  extra Tick-qualified cycles to wait after select before capture (>=0)
// PORTS
//  Clock     in   1         system clock, rising edge
//  Reset     in   1         asynchronous, active-high
//  Tick      in   1         scan-progress enable (one-cycle strobe or tied 1)
//  Start     in   1         request a scan; honoured only in IDLE on a Tick edge
//  Mask      in   NrOfRegs  1 = include register i in the scan; sampled with Start
//  BusIn     in   NrOfBits  shared tristate bus from the registers' Q outputs
//  Cs        out  NrOfRegs  per-register chip select, 0 = drive bus, 1 = high-Z
//  OutValid  out  1         OutData/OutIndex hold a captured word
//  OutReady  in   1         consumer accepts the word when OutValid&OutReady at a rising edge
//  OutData   out  NrOfBits  captured bus value
//  OutIndex  out  IdxW      index of the register that produced OutData
//  Busy      out  1         1 in any state other than IDLE
//  Done      out  1         one-cycle pulse when the scan completes
// BEHAVIOUR
//  - Reset (async, any state): Cs all 1, OutValid 0, OutData 0, OutIndex 0, Busy 0, Done 0,
//    latched mask 0, state IDLE. Reset mid-scan drops the scan and leaves no Cs low.
//  - States: IDLE, SETTLE, OUTPUT, FINISH.
//  - Invariant: at most one Cs bit is 0 at any time. Cs is all 1 in IDLE, OUTPUT and FINISH.
//  - IDLE, edge with Start&Tick: latch Mask.
//    - If latched mask is 0: go to FINISH.
//    - Else: drive Cs[i]=0 for the lowest set index i, load the settle counter with
//      SettleCycles, and go to SETTLE.
//  - SETTLE: each Tick edge, if the counter is nonzero, decrement it.
//    - If the counter is 0: capture OutData<=BusIn and OutIndex<=i, set OutValid=1,
//      set all Cs to 1, clear mask bit i, and go to OUTPUT.
//    - Capture occurs SettleCycles+1 Tick edges after Cs goes low.
//    - Non-Tick edges hold all state.
//  - OUTPUT: OutData/OutIndex are stable while OutValid=1 and OutReady=0.
//    - On the OutValid&OutReady edge (independent of Tick): clear OutValid.
//    - If the remaining mask is nonzero: select the next lowest set index, reload the counter,
//      and go to SETTLE.
//    - Else: go to FINISH.
//  - FINISH: Done=1 for exactly one cycle, then IDLE. Busy falls with Done.
//  - Start is ignored while Busy=1; a Start held high across FINISH->IDLE begins a new scan on
//    the next Tick edge.
//  - OutData retains the last captured word after the scan; only OutValid qualifies it.
//  - Index order: ascending. Indices >= NrOfRegs are never generated.
// STRUCTURE
//  - Shared package: state encoding localparams (IDLE/SETTLE/OUTPUT/FINISH) and a clog2 function
//    used for IdxW and the settle counter width (clog2(SettleCycles+1), min 1).
//  - One sub-module: pipe_reg_next_sel, a combinational lowest-set-bit finder
//    (mask -> index, any).
//  - Cs is registered, never decoded combinationally, so the bus carries no glitch drivers.
// TESTING (bench models NrOfRegs tristate registers on BusIn; NrOfBits=32, NrOfRegs=8, SettleCycles=1)
//  1 Regs preloaded 0x1000_0000+i, Mask=0xFF, Tick=1, OutReady=1, pulse Start -> 8 words,
//    idx 0..7, data matches; Done pulses once; Cs never has two zeros.
//  2 Mask=0x05, OutReady held 0 for 5 cycles after the first OutValid -> OutData/OutIndex
//    stable (idx 0), Cs all 1 during the stall; then idx 2; then Done.
//  3 Mask=0x00, Start -> no OutValid; Done one cycle later; Busy high for exactly that span.
//  4 Tick pulsed every 4th cycle, Mask=0x80 -> capture 2 Tick edges after Cs[7] falls;
//    OutIndex=7.
//  5 Reset asserted while in SETTLE with Cs[3]=0 -> Cs=0xFF, OutValid=0, Busy=0 immediately
//    (async).
//  6 Start re-pulsed mid-scan -> ignored; scan count and order unchanged.

Source files
------------

// File: rtl/pipe_reg_bus_reader_pkg.sv
// Shared definitions for the pipeline-register bus reader: FSM encoding and width helper.
package pipe_reg_bus_reader_pkg;

  localparam logic [1:0] ENC_IDLE   = 2'd0;
  localparam logic [1:0] ENC_SETTLE = 2'd1;
  localparam logic [1:0] ENC_OUTPUT = 2'd2;
  localparam logic [1:0] ENC_FINISH = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ENC_IDLE,
    SETTLE = ENC_SETTLE,
    OUTPUT = ENC_OUTPUT,
    FINISH = ENC_FINISH
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_bus_reader_next_sel.sv
// Lowest-set-bit finder: picks the next register to select from the remaining scan mask.
module pipe_reg_next_sel #(
  parameter int N    = 8,
  parameter int IdxW = 3
) (
  input  logic [N-1:0]    mask,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  // Walk downward so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (mask[i]) idx = IdxW'(i);
  end

  assign any = |mask;

endmodule

// File: rtl/pipe_reg_bus_reader.sv
// Reader for the shared tristate pipeline-register bus: selects each masked register in turn,
// waits for the bus to settle, captures it and streams it out over valid/ready.
module pipe_reg_bus_reader
  import pipe_reg_bus_reader_pkg::*;
#(
  parameter int NrOfBits     = 32,
  parameter int NrOfRegs     = 8,
  parameter int SettleCycles = 1,
  localparam int IdxW        = (clog2(NrOfRegs) < 1) ? 1 : clog2(NrOfRegs)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                Start,
  input  logic [NrOfRegs-1:0] Mask,
  input  logic [NrOfBits-1:0] BusIn,
  output logic [NrOfRegs-1:0] Cs,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [NrOfBits-1:0] OutData,
  output logic [IdxW-1:0]     OutIndex,
  output logic                Busy,
  output logic                Done
);

  localparam int CntW = (clog2(SettleCycles + 1) < 1) ? 1 : clog2(SettleCycles + 1);

  state_t              state_q, state_d;
  logic [NrOfRegs-1:0] cs_q, cs_d;
  logic [NrOfRegs-1:0] mask_q, mask_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     sel_q, sel_d;
  logic                valid_q, valid_d;
  logic [NrOfBits-1:0] data_q, data_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  logic [NrOfRegs-1:0] find_mask;
  logic [IdxW-1:0]     nxt_idx;
  logic                nxt_any;

  // In IDLE the first pick comes straight from the Mask input being latched.
  assign find_mask = (state_q == IDLE) ? Mask : mask_q;

  pipe_reg_next_sel #(.N(NrOfRegs), .IdxW(IdxW)) u_next_sel (
    .mask (find_mask),
    .idx  (nxt_idx),
    .any  (nxt_any)
  );

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (Start && Tick) begin
        mask_d = Mask;
        if (!nxt_any) state_d = FINISH;
        else begin
          cs_d          = '1;
          cs_d[nxt_idx] = 1'b0;
          sel_d         = nxt_idx;
          cnt_d         = CntW'(SettleCycles);
          state_d       = SETTLE;
        end
      end
      SETTLE: if (Tick) begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        else begin
          data_d        = BusIn;
          idx_d         = sel_q;
          valid_d       = 1'b1;
          cs_d          = '1;
          mask_d[sel_q] = 1'b0;
          state_d       = OUTPUT;
        end
      end
      OUTPUT: if (valid_q && OutReady) begin
        valid_d = 1'b0;
        if (nxt_any) begin
          cs_d          = '1;
          cs_d[nxt_idx] = 1'b0;
          sel_d         = nxt_idx;
          cnt_d         = CntW'(SettleCycles);
          state_d       = SETTLE;
        end else state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cs_q    <= '1;
      mask_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign Cs       = cs_q;
  assign OutValid = valid_q;
  assign OutData  = data_q;
  assign OutIndex = idx_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == FINISH);

endmodule
